// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for the instruction encoder.
// The slave modport is the encoder; the master modport is the requester
// together with the memory that answers the write strobe.
interface instr_encoder_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  op_sel_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  logic [4:0]  shamt_i;
  logic [5:0]  funct_i;
  logic [15:0] imm_i;
  logic [25:0] target_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;

  modport slave (
    input  in_valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i, funct_i,
           imm_i, target_i, mem_ack_i,
    output in_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output in_valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i, funct_i,
           imm_i, target_i, mem_ack_i,
    input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: turns a mnemonic request into a 32-bit MIPS-style
// word and writes it to consecutive instruction-memory addresses.
//
// state | meaning
// IDLE  | ready for a request (unless the word counter is full)
// WRITE | mem_we_o held with address/data until mem_ack_i
// ERR   | invalid mnemonic seen; waits for clear_i
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  instr_encoder_if.slave bus,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [31:0] enc_word;
  logic        op_invalid;
  logic        full;
  logic        ready;

  assign full       = (count_q == CW'(DEPTH));
  assign ready      = (state_q == S_IDLE) && !full;
  assign op_invalid = (bus.op_sel_i[3:1] == 3'b111);

  // Combinational encode of the current request fields.
  always_comb begin
    enc_word = 32'd0;
    case (bus.op_sel_i)
      4'd0:  enc_word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, bus.shamt_i, bus.funct_i};
      4'd1:  enc_word = {6'b001000, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd2:  enc_word = {6'b001011, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd3:  enc_word = {6'b000100, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd4:  enc_word = {6'b001111, 5'd0,     bus.rt_i, bus.imm_i};
      4'd5:  enc_word = {6'b001101, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd6:  enc_word = {6'b000101, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd7:  enc_word = {6'b100011, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd8:  enc_word = {6'b101011, bus.rs_i, bus.rt_i, bus.imm_i};
      4'd9:  enc_word = {6'b000110, bus.rs_i, 5'd0,     bus.imm_i};
      4'd10: enc_word = {6'b000111, bus.rs_i, 5'd0,     bus.imm_i};
      4'd11: enc_word = {6'b000000, bus.rs_i, 15'd0,    6'b001000};
      4'd12: enc_word = {6'b000010, bus.target_i};
      4'd13: enc_word = {6'b000011, bus.target_i};
      default: enc_word = 32'd0;
    endcase
  end

  // Next-state logic; clear_i outranks a same-cycle acceptance in IDLE.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (clear_i) begin
          count_d = '0;
          err_d   = 1'b0;
        end else if (bus.in_valid_i && ready) begin
          if (op_invalid) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            data_d  = enc_word;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            we_d    = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (bus.mem_ack_i) begin
          we_d    = 1'b0;
          count_d = count_q + CW'(1);
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (clear_i) begin
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset wins over everything, including a pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready_o = ready;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign count_o        = count_q;
  assign full_o         = full;
  assign err_o          = err_q;

endmodule
